// File: rtl/cnn_sdiv_21s_7ns_seq.sv
// Sequential restoring divider: signed 21-bit dividend by unsigned 7-bit scale, 14-bit signed quotient.
// Define CNN_DIV_SAT_EN to saturate the quotient on overflow; otherwise it wraps to its low bits.
module cnn_sdiv_21s_7ns_seq #(
    parameter int DIVIDEND_W = 21,
    parameter int DIVISOR_W  = 7,
    parameter int QUOT_W     = 14
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic        [DIVISOR_W-1:0]  divisor,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [QUOT_W-1:0]     quot,
    output logic signed [DIVISOR_W:0]    rem,
    output logic                         ovf,
    output logic                         dz
);

    localparam int REM_W = DIVISOR_W + 1;
    localparam int CNT_W = $clog2(DIVIDEND_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0]         LAST_ITER = CNT_W'(DIVIDEND_W - 1);
    localparam logic signed [QUOT_W-1:0] Q_MAX     = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic signed [QUOT_W-1:0] Q_MIN     = {1'b1, {(QUOT_W-1){1'b0}}};
    localparam logic [DIVIDEND_W-1:0]    POS_LIMIT = DIVIDEND_W'((1 << (QUOT_W - 1)) - 1);
    localparam logic [DIVIDEND_W-1:0]    NEG_LIMIT = DIVIDEND_W'(1 << (QUOT_W - 1));

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  neg;
    logic [DIVIDEND_W-1:0] mag;
    logic [DIVISOR_W-1:0]  dvsr;
    logic [DIVISOR_W-1:0]  prem;

    logic                     accept;
    logic                     in_neg;
    logic [DIVIDEND_W-1:0]    in_mag;
    logic [REM_W-1:0]         shifted;
    logic [REM_W-1:0]         diff;
    logic                     take;
    logic [DIVISOR_W-1:0]     prem_next;
    logic                     q_neg;
    logic                     ovf_calc;
    logic signed [QUOT_W-1:0] quot_calc;
    logic signed [REM_W-1:0]  rem_calc;

    // mag doubles as the quotient shift register: dividend bits leave at the top
    // while quotient bits enter at the bottom, so after the last step it holds |quotient|.
    always_comb begin
        accept    = in_valid && in_ready && (state == S_IDLE);
        in_neg    = dividend[DIVIDEND_W-1];
        in_mag    = in_neg ? (~dividend + DIVIDEND_W'(1)) : dividend;
        shifted   = {prem, mag[DIVIDEND_W-1]};
        take      = (shifted >= {1'b0, dvsr});
        diff      = shifted - {1'b0, dvsr};
        prem_next = DIVISOR_W'(take ? diff : shifted);
        q_neg     = neg && (mag != '0);
        ovf_calc  = q_neg ? (mag > NEG_LIMIT) : (mag > POS_LIMIT);
        quot_calc = QUOT_W'(q_neg ? (~mag + DIVIDEND_W'(1)) : mag);
        rem_calc  = REM_W'(neg ? (~{1'b0, prem} + REM_W'(1)) : {1'b0, prem});
`ifdef CNN_DIV_SAT_EN
        if (ovf_calc) begin
            quot_calc = q_neg ? Q_MIN : Q_MAX;
        end
`endif
    end

    // A zero divisor skips the iterations but still passes through the result register stage.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            neg       <= 1'b0;
            mag       <= '0;
            dvsr      <= '0;
            prem      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        neg      <= in_neg;
                        mag      <= in_mag;
                        dvsr     <= divisor;
                        prem     <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= (divisor == '0) ? S_FINAL : S_CALC;
                    end
                end
                S_CALC: begin
                    prem <= prem_next;
                    mag  <= {mag[DIVIDEND_W-2:0], take};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    if (dvsr == '0) begin
                        quot <= neg ? Q_MIN : Q_MAX;
                        rem  <= '0;
                        ovf  <= 1'b0;
                        dz   <= 1'b1;
                    end else begin
                        quot <= quot_calc;
                        rem  <= rem_calc;
                        ovf  <= ovf_calc;
                        dz   <= 1'b0;
                    end
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_sdiv_21s_7ns_seq.sv
// Scoreboard bench for cnn_sdiv_21s_7ns_seq; expectations follow CNN_DIV_SAT_EN when it is defined.
module tb_cnn_sdiv_21s_7ns_seq;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [20:0] dividend;
    logic        [6:0]  divisor;
    logic               out_valid;
    logic               out_ready;
    logic signed [13:0] quot;
    logic signed [7:0]  rem;
    logic               ovf;
    logic               dz;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic signed [13:0] quot;
        logic signed [7:0]  rem;
        logic               ovf;
        logic               dz;
        int                 lat;
    } exp_t;

    exp_t sb[$];

    cnn_sdiv_21s_7ns_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model from integer arithmetic: SV '/' truncates toward zero, '%' follows the dividend sign.
    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int   q;
        if (b == 0) begin
            e.dz   = 1'b1;
            e.ovf  = 1'b0;
            e.rem  = 8'sd0;
            e.quot = 14'((a >= 0) ? 8191 : -8192);
            e.lat  = 1;
        end else begin
            q      = a / b;
            e.dz   = 1'b0;
            e.rem  = 8'(a % b);
            e.ovf  = (q > 8191) || (q < -8192);
            e.quot = 14'(q);
`ifdef CNN_DIV_SAT_EN
            if (e.ovf) e.quot = 14'((q > 0) ? 8191 : -8192);
`endif
            e.lat  = 22;
        end
        return e;
    endfunction

    task automatic send(input int a, input int b, output bit ok);
        dividend = 21'(a);
        divisor  = 7'(b);
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge ap_clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge ap_clk); #1;
        end
        in_valid = 1'b0;
        if (ok) sb.push_back(model(a, b));
    endtask

    task automatic collect(output logic signed [13:0] q, output logic signed [7:0] r,
                           output logic o, output logic z, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 200) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge ap_clk); #1;
            cyc++;
        end
        q = quot;
        r = rem;
        o = ovf;
        z = dz;
        if (ok && out_ready) begin
            @(posedge ap_clk); #1;
        end
    endtask

    task automatic test_reset();
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, quot, rem, ovf, dz} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got in_ready=%b out_valid=%b quot=%0d rem=%0d ovf=%b dz=%b, want all 0",
                     in_ready, out_valid, quot, rem, ovf, dz);
        end
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ready_after_reset: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        int a_tab[6] = '{-1000, 100, 1040257, -8192, 8192, -1048576};
        int b_tab[6] = '{7, 127, 127, 1, 1, 3};
        logic signed [13:0] q;
        logic signed [7:0]  r;
        logic o, z;
        int   cyc;
        bit   ok;
        exp_t e;
        foreach (a_tab[i]) begin
            send(a_tab[i], b_tab[i], ok);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL basic_accept %0d/%0d: in_ready never high, want 1", a_tab[i], b_tab[i]);
                continue;
            end
            collect(q, r, o, z, cyc, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || q !== e.quot || r !== e.rem || o !== e.ovf || z !== e.dz || cyc != e.lat) begin
                n_fail++;
                $display("[TB] FAIL basic %0d/%0d: got quot=%0d rem=%0d ovf=%b dz=%b lat=%0d, want quot=%0d rem=%0d ovf=%b dz=%b lat=%0d",
                         a_tab[i], b_tab[i], q, r, o, z, cyc, e.quot, e.rem, e.ovf, e.dz, e.lat);
            end
        end
    endtask

    task automatic test_div_zero();
        int a_tab[3] = '{500, -5, 0};
        logic signed [13:0] q;
        logic signed [7:0]  r;
        logic o, z;
        int   cyc;
        bit   ok;
        exp_t e;
        foreach (a_tab[i]) begin
            send(a_tab[i], 0, ok);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL dz_accept %0d/0: in_ready never high, want 1", a_tab[i]);
                continue;
            end
            collect(q, r, o, z, cyc, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || q !== e.quot || r !== e.rem || o !== e.ovf || z !== e.dz || cyc != e.lat) begin
                n_fail++;
                $display("[TB] FAIL div_zero %0d/0: got quot=%0d rem=%0d ovf=%b dz=%b lat=%0d, want quot=%0d rem=%0d ovf=%b dz=%b lat=%0d",
                         a_tab[i], q, r, o, z, cyc, e.quot, e.rem, e.ovf, e.dz, e.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [13:0] q;
        logic signed [7:0]  r;
        logic o, z;
        int   cyc;
        int   bad = 0;
        bit   ok;
        exp_t e;
        out_ready = 1'b0;
        send(12345, 99, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL bp_accept: in_ready never high, want 1");
            out_ready = 1'b1;
            return;
        end
        collect(q, r, o, z, cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || q !== e.quot || r !== e.rem || o !== e.ovf || z !== e.dz || cyc != e.lat) begin
            n_fail++;
            $display("[TB] FAIL bp_result 12345/99: got quot=%0d rem=%0d ovf=%b dz=%b lat=%0d, want quot=%0d rem=%0d ovf=%b dz=%b lat=%0d",
                     q, r, o, z, cyc, e.quot, e.rem, e.ovf, e.dz, e.lat);
        end
        in_valid = 1'b1;
        dividend = -21'sd77;
        divisor  = 7'd3;
        repeat (10) begin
            @(posedge ap_clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== e.quot || rem !== e.rem ||
                ovf !== e.ovf || dz !== e.dz) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL bp_hold: got %0d unstable cycles, want 0", bad);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        logic signed [13:0] q;
        logic signed [7:0]  r;
        logic o, z;
        int   cyc;
        int   seen = 0;
        bit   ok;
        exp_t e;
        send(1000, 7, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL rst_accept: in_ready never high, want 1");
            return;
        end
        repeat (10) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        void'(sb.pop_front());
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rst_mid_calc: got out_valid=%b in_ready=%b, want 0 0", out_valid, in_ready);
        end
        ap_rst = 1'b0;
        repeat (30) begin
            @(posedge ap_clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("[TB] FAIL rst_discard: got %0d out_valid cycles, want 0", seen);
        end
        send(21, 7, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL rst_reaccept: in_ready never high, want 1");
            return;
        end
        collect(q, r, o, z, cyc, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || q !== e.quot || r !== e.rem || o !== e.ovf || z !== e.dz || cyc != e.lat) begin
            n_fail++;
            $display("[TB] FAIL after_reset 21/7: got quot=%0d rem=%0d ovf=%b dz=%b lat=%0d, want quot=%0d rem=%0d ovf=%b dz=%b lat=%0d",
                     q, r, o, z, cyc, e.quot, e.rem, e.ovf, e.dz, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [13:0] q;
        logic signed [7:0]  r;
        logic o, z;
        int   cyc;
        int   a;
        int   b;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            a = int'($urandom_range(2097151, 0)) - 1048576;
            b = int'($urandom_range(127, 0));
            if (i == 0) a = 1048575;
            if (i == 1) a = 0;
            send(a, b, ok);
            n_cmp++;
            if (!ok) begin
                n_fail++;
                $display("[TB] FAIL b2b_accept %0d/%0d: in_ready never high, want 1", a, b);
                continue;
            end
            collect(q, r, o, z, cyc, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || q !== e.quot || r !== e.rem || o !== e.ovf || z !== e.dz || cyc != e.lat) begin
                n_fail++;
                $display("[TB] FAIL b2b %0d/%0d: got quot=%0d rem=%0d ovf=%b dz=%b lat=%0d, want quot=%0d rem=%0d ovf=%b dz=%b lat=%0d",
                         a, b, q, r, o, z, cyc, e.quot, e.rem, e.ovf, e.dz, e.lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
